// File: rtl/zynq_axil_csr_shell_pkg.sv
// zynq_axil_csr_shell_pkg: address map, response codes and FSM states shared by the CSR shell.
package zynq_axil_csr_shell_pkg;
  localparam logic [7:0] PS2PL_PUSH_OFF = 8'h40;
  localparam logic [7:0] PS2PL_FREE_OFF = 8'h44;
  localparam logic [7:0] PL2PS_POP_OFF  = 8'h48;
  localparam logic [7:0] PL2PS_CNT_OFF  = 8'h4C;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: register-based word FIFO, valid-ready in, valid-yumi out, with occupancy count.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 32,
  parameter int els_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [width_p-1:0]           data_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);
  localparam int pw = $clog2(els_p);
  localparam int cw = $clog2(els_p+1);
  logic [width_p-1:0] mem_q [els_p];
  logic [pw-1:0] wptr_q, rptr_q;
  logic [cw-1:0] cnt_q;
  logic push, pop;
  assign ready_o = cnt_q != cw'(els_p);
  assign v_o     = cnt_q != '0;
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk_i)
    if (push) mem_q[wptr_q] <= data_i;
  // power-of-two depth lets the pointers wrap on their own
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + pw'(push);
      rptr_q <= rptr_q + pw'(pop);
      cnt_q  <= cnt_q + cw'(push) - cw'(pop);
    end
endmodule

// File: rtl/zynq_axil_csr_shell.sv
// zynq_axil_csr_shell: AXI4-Lite slave with RW CSRs, a PS-to-PL command FIFO and a PL-to-PS response FIFO.
module zynq_axil_csr_shell
  import zynq_axil_csr_shell_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int num_regs_p   = 4,
  parameter int fifo_els_p   = 8
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [addr_width_p-1:0]            s_axil_awaddr,
  input  logic [2:0]                         s_axil_awprot,
  input  logic                               s_axil_awvalid,
  output logic                               s_axil_awready,
  input  logic [data_width_p-1:0]            s_axil_wdata,
  input  logic [data_width_p/8-1:0]          s_axil_wstrb,
  input  logic                               s_axil_wvalid,
  output logic                               s_axil_wready,
  output logic [1:0]                         s_axil_bresp,
  output logic                               s_axil_bvalid,
  input  logic                               s_axil_bready,
  input  logic [addr_width_p-1:0]            s_axil_araddr,
  input  logic [2:0]                         s_axil_arprot,
  input  logic                               s_axil_arvalid,
  output logic                               s_axil_arready,
  output logic [data_width_p-1:0]            s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic                               s_axil_rvalid,
  input  logic                               s_axil_rready,
  output logic [num_regs_p*data_width_p-1:0] csr_data_o,
  output logic [data_width_p-1:0]            ps2pl_data_o,
  output logic                               ps2pl_v_o,
  input  logic                               ps2pl_yumi_i,
  input  logic [data_width_p-1:0]            pl2ps_data_i,
  input  logic                               pl2ps_v_i,
  output logic                               pl2ps_ready_o
);
  localparam int iw = addr_width_p - 2;
  localparam int cw = $clog2(fifo_els_p+1);
  localparam int sw = data_width_p / 8;
  localparam logic [iw-1:0] PUSH_W = iw'(PS2PL_PUSH_OFF >> 2);
  localparam logic [iw-1:0] FREE_W = iw'(PS2PL_FREE_OFF >> 2);
  localparam logic [iw-1:0] POP_W  = iw'(PL2PS_POP_OFF >> 2);
  localparam logic [iw-1:0] CNT_W  = iw'(PL2PS_CNT_OFF >> 2);
  logic [1:0] rst_sync_q;
  logic rst_n;
  w_state_e w_state_q;
  r_state_e r_state_q;
  logic aw_held_q, w_held_q;
  logic [addr_width_p-1:0] awaddr_q;
  logic [data_width_p-1:0] wdata_q, rdata_q, rdata_d;
  logic [sw-1:0] wstrb_q;
  logic [1:0] bresp_q, rresp_q, rresp_d;
  logic [num_regs_p-1:0][data_width_p-1:0] csr_q, csr_d;
  logic aw_hs, w_hs, ar_hs, aw_have, w_have, commit;
  logic [addr_width_p-1:0] waddr;
  logic [data_width_p-1:0] wdat;
  logic [sw-1:0] wstb;
  logic [iw-1:0] widx, ridx;
  logic wr_csr, wr_push, rd_pop;
  logic ps2pl_ready, pl2ps_v;
  logic [data_width_p-1:0] pl2ps_data;
  logic [cw-1:0] ps2pl_cnt, pl2ps_cnt;
  logic unused_ok;
  // reset asserts immediately but releases on a clock edge
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  assign s_axil_awready = rst_n & (w_state_q == W_IDLE) & ~aw_held_q;
  assign s_axil_wready  = rst_n & (w_state_q == W_IDLE) & ~w_held_q;
  assign s_axil_bvalid  = w_state_q == W_RESP;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = rst_n & (r_state_q == R_IDLE);
  assign s_axil_rvalid  = r_state_q == R_RESP;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign csr_data_o     = csr_q;
  assign aw_hs   = s_axil_awvalid & s_axil_awready;
  assign w_hs    = s_axil_wvalid & s_axil_wready;
  assign ar_hs   = s_axil_arvalid & s_axil_arready;
  assign aw_have = aw_held_q | aw_hs;
  assign w_have  = w_held_q | w_hs;
  assign commit  = aw_have & w_have;
  assign waddr   = aw_held_q ? awaddr_q : s_axil_awaddr;
  assign wdat    = w_held_q ? wdata_q : s_axil_wdata;
  assign wstb    = w_held_q ? wstrb_q : s_axil_wstrb;
  assign widx    = waddr[addr_width_p-1:2];
  assign ridx    = s_axil_araddr[addr_width_p-1:2];
  assign wr_csr  = widx < iw'(num_regs_p);
  assign wr_push = widx == PUSH_W;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, waddr[1:0], s_axil_araddr[1:0]};
  always_comb begin
    csr_d = csr_q;
    for (int k = 0; k < num_regs_p; k++)
      for (int b = 0; b < sw; b++)
        if (commit && wr_csr && widx == iw'(k) && wstb[b]) csr_d[k][8*b+:8] = wdat[8*b+:8];
  end
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    rd_pop  = 1'b0;
    for (int k = 0; k < num_regs_p; k++)
      if (ridx == iw'(k)) begin
        rdata_d = csr_q[k];
        rresp_d = RESP_OKAY;
      end
    if (ridx == FREE_W) begin
      rdata_d = data_width_p'(cw'(fifo_els_p) - ps2pl_cnt);
      rresp_d = RESP_OKAY;
    end else if (ridx == CNT_W) begin
      rdata_d = data_width_p'(pl2ps_cnt);
      rresp_d = RESP_OKAY;
    end else if (ridx == POP_W && pl2ps_v) begin
      rdata_d = pl2ps_data;
      rresp_d = RESP_OKAY;
      rd_pop  = ar_hs;
    end
  end
  always_ff @(posedge aclk or negedge rst_n)
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      csr_q     <= '0;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_have & ~commit;
      w_held_q  <= w_have & ~commit;
      awaddr_q  <= waddr;
      wdata_q   <= wdat;
      wstrb_q   <= wstb;
      csr_q     <= csr_d;
      w_state_q <= commit ? W_RESP : (s_axil_bvalid & s_axil_bready) ? W_IDLE : w_state_q;
      if (commit) bresp_q <= (wr_csr | (wr_push & ps2pl_ready)) ? RESP_OKAY : RESP_SLVERR;
      r_state_q <= ar_hs ? R_RESP : (s_axil_rvalid & s_axil_rready) ? R_IDLE : r_state_q;
      if (ar_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) ps2pl_fifo (
    .clk_i(aclk), .rst_ni(rst_n),
    .v_i(commit & wr_push), .ready_o(ps2pl_ready), .data_i(wdat),
    .v_o(ps2pl_v_o), .data_o(ps2pl_data_o), .yumi_i(ps2pl_yumi_i),
    .count_o(ps2pl_cnt)
  );
  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) pl2ps_fifo (
    .clk_i(aclk), .rst_ni(rst_n),
    .v_i(pl2ps_v_i), .ready_o(pl2ps_ready_o), .data_i(pl2ps_data_i),
    .v_o(pl2ps_v), .data_o(pl2ps_data), .yumi_i(rd_pop),
    .count_o(pl2ps_cnt)
  );
endmodule

// File: tb/tb_zynq_axil_csr_shell.sv
// tb_zynq_axil_csr_shell: directed self-checking bench for the AXI-Lite CSR/FIFO shell.
module tb_zynq_axil_csr_shell;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [9:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [127:0] csr_data;
  logic [31:0] ps2pl_data, pl2ps_data = '0;
  logic ps2pl_v, ps2pl_yumi = 0, pl2ps_v = 0, pl2ps_ready;
  int checks = 0, errors = 0;
  logic [1:0] resp;
  logic [31:0] data;

  always #5 aclk = ~aclk;

  zynq_axil_csr_shell dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .csr_data_o(csr_data),
    .ps2pl_data_o(ps2pl_data), .ps2pl_v_o(ps2pl_v), .ps2pl_yumi_i(ps2pl_yumi),
    .pl2ps_data_i(pl2ps_data), .pl2ps_v_i(pl2ps_v), .pl2ps_ready_o(pl2ps_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no handshake expected one within budget", tag);
  endtask

  task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    logic ag, wg, got;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      @(negedge aclk);
      ag = awvalid & awready;
      wg = wvalid & wready;
      @(posedge aclk); #1;
      if (ag) awvalid = 0;
      if (wg) wvalid = 0;
    end
    if (awvalid || wvalid) begin
      timeout("write_accept");
      awvalid = 0; wvalid = 0;
    end
    got = 0;
    r = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (bvalid) begin r = bresp; got = 1; end
      @(posedge aclk); #1;
    end
    if (!got) timeout("write_bvalid");
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] r);
    logic ag, got;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      @(negedge aclk);
      ag = arready;
      @(posedge aclk); #1;
      if (ag) arvalid = 0;
    end
    if (arvalid) begin timeout("read_accept"); arvalid = 0; end
    got = 0;
    d = '1; r = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (rvalid) begin d = rdata; r = rresp; got = 1; end
      @(posedge aclk); #1;
    end
    if (!got) timeout("read_rvalid");
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 64'(awready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_arready", 64'(arready), 0);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_csr_lo", csr_data[63:0], 0);
    check("rst_csr_hi", csr_data[127:64], 0);
    aresetn = 1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ps2pl_v", 64'(ps2pl_v), 0);
    check("rst_pl2ps_ready", 64'(pl2ps_ready), 1);
    check("rst_awready_up", 64'(awready), 1);

    // CSR byte-masked write
    axi_write(10'h004, 32'hFFFF_FFFF, 4'hF, resp);
    check("csr1_init_resp", 64'(resp), 0);
    axi_write(10'h004, 32'hA5A5_0001, 4'b0011, resp);
    check("csr1_mask_resp", 64'(resp), 0);
    axi_read(10'h004, data, resp);
    check("csr1_rdata", 64'(data), 64'hFFFF_0001);
    check("csr1_rresp", 64'(resp), 0);
    check("csr1_out", 64'(csr_data[63:32]), 64'hFFFF_0001);

    // W three cycles before AW, bready held low
    bready = 0;
    awaddr = 10'h008; wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1;
    @(negedge aclk);
    check("wfirst_wready", 64'(wready), 1);
    @(posedge aclk); #1;
    wvalid = 0;
    repeat (3) @(posedge aclk);
    #1;
    awvalid = 1;
    @(negedge aclk);
    check("wfirst_awready", 64'(awready), 1);
    check("wfirst_bvalid_pre", 64'(bvalid), 0);
    @(posedge aclk); #1;
    awvalid = 0;
    @(negedge aclk);
    check("wfirst_bvalid_post", 64'(bvalid), 1);
    check("wfirst_csr2", 64'(csr_data[95:64]), 64'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bhold_bvalid", 64'(bvalid), 1);
      check("bhold_awready", 64'(awready), 0);
    end
    check("wfirst_bresp", 64'(bresp), 0);
    bready = 1;
    @(posedge aclk); #1;
    check("wfirst_bvalid_done", 64'(bvalid), 0);

    // fill ps2pl
    for (int i = 0; i < 8; i++) begin
      axi_write(10'h040, 32'h100 + 32'(i), 4'h0, resp);
      check("ps2pl_push_resp", 64'(resp), 0);
    end
    axi_read(10'h044, data, resp);
    check("ps2pl_free_full", 64'(data), 0);
    axi_write(10'h040, 32'hDEAD, 4'hF, resp);
    check("ps2pl_push_full", 64'(resp), 2);
    check("ps2pl_head", 64'(ps2pl_data), 64'h100);
    check("ps2pl_v_full", 64'(ps2pl_v), 1);
    ps2pl_yumi = 1;
    @(posedge aclk); #1;
    ps2pl_yumi = 0;
    check("ps2pl_next", 64'(ps2pl_data), 64'h101);
    axi_read(10'h044, data, resp);
    check("ps2pl_free_1", 64'(data), 1);
    ps2pl_yumi = 1;
    repeat (4) @(posedge aclk);
    #1;
    ps2pl_yumi = 0;
    axi_read(10'h044, data, resp);
    check("ps2pl_free_5", 64'(data), 5);
    check("ps2pl_head_5", 64'(ps2pl_data), 64'h105);

    // pl2ps
    pl2ps_data = 32'h1234; pl2ps_v = 1;
    @(negedge aclk);
    check("pl2ps_ready", 64'(pl2ps_ready), 1);
    @(posedge aclk); #1;
    pl2ps_data = 32'h5678;
    @(posedge aclk); #1;
    pl2ps_v = 0;
    axi_read(10'h04C, data, resp);
    check("pl2ps_cnt2", 64'(data), 2);
    axi_read(10'h048, data, resp);
    check("pl2ps_pop1", 64'(data), 64'h1234);
    check("pl2ps_pop1_resp", 64'(resp), 0);
    axi_read(10'h048, data, resp);
    check("pl2ps_pop2", 64'(data), 64'h5678);
    axi_read(10'h048, data, resp);
    check("pl2ps_empty_data", 64'(data), 0);
    check("pl2ps_empty_resp", 64'(resp), 2);
    axi_read(10'h04C, data, resp);
    check("pl2ps_cnt0", 64'(data), 0);

    // unmapped and read-only
    axi_write(10'h3F0, 32'hFFFF_FFFF, 4'hF, resp);
    check("unmap_wresp", 64'(resp), 2);
    axi_read(10'h3F0, data, resp);
    check("unmap_rdata", 64'(data), 0);
    check("unmap_rresp", 64'(resp), 2);
    axi_write(10'h044, 32'hFFFF_FFFF, 4'hF, resp);
    check("ro_wresp", 64'(resp), 2);
    check("unmap_csr_lo", csr_data[63:0], 64'hFFFF_0001_0000_0000);
    check("unmap_csr_hi", csr_data[127:64], 64'h0000_0000_1122_3344);
    axi_read(10'h044, data, resp);
    check("unmap_free", 64'(data), 5);

    // reset while rvalid pending and ps2pl holds 3 words
    rready = 0;
    araddr = 10'h008; arvalid = 1;
    @(negedge aclk);
    check("rstmid_arready", 64'(arready), 1);
    @(posedge aclk); #1;
    arvalid = 0;
    @(negedge aclk);
    check("rstmid_rvalid_pre", 64'(rvalid), 1);
    check("rstmid_ps2pl_pre", 64'(ps2pl_v), 1);
    #1 aresetn = 0;
    #1;
    check("rstmid_rvalid", 64'(rvalid), 0);
    check("rstmid_ps2pl_v", 64'(ps2pl_v), 0);
    rready = 1;
    @(posedge aclk); #1;
    aresetn = 1;
    repeat (3) @(posedge aclk);
    #1;
    check("rstmid_rvalid_after", 64'(rvalid), 0);
    check("rstmid_bvalid_after", 64'(bvalid), 0);
    check("rstmid_ps2pl_after", 64'(ps2pl_v), 0);
    for (int k = 0; k < 4; k++) begin
      axi_read(10'(4 * k), data, resp);
      check("rstmid_csr_read", 64'(data), 0);
      check("rstmid_csr_resp", 64'(resp), 0);
    end
    check("rstmid_csr_out", csr_data[63:0] | csr_data[127:64], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end
endmodule
